// File: rtl/handshake_fsm_mc_pkg.sv
// Shared types and constants for the multi-channel four-phase handshake responder.
package hs_pkg;

  localparam int HS_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DELAY = 2'b01,
    ACK   = 2'b10,
    ERR   = 2'b11
  } hs_state_t;

  // Number of set bits in an up-to-8-bit vector (channel count is capped at 8).
  function automatic logic [3:0] hs_popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/handshake_fsm_mc_if.sv
// Bundles the per-channel req/ack/err lines and the shared status of the responder.
interface handshake_fsm_mc_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8
);

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] ack;
  logic [NUM_CH-1:0] err;
  logic              err_clr;
  logic              busy;
  logic [CNT_W-1:0]  txn_cnt;

  modport master (
    output req,
    output err_clr,
    input  ack,
    input  err,
    input  busy,
    input  txn_cnt
  );

  modport slave (
    input  req,
    input  err_clr,
    output ack,
    output err,
    output busy,
    output txn_cnt
  );

endinterface

// File: rtl/handshake_fsm_mc_chan.sv
// One handshake channel: optional req synchroniser, IDLE/DELAY/ACK/ERR FSM and cycle counter.
module hs_chan
  import hs_pkg::*;
#(
  parameter int unsigned ACK_DELAY = 2,
  parameter int unsigned TIMEOUT   = 16,
  parameter bit          SYNC_EN   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic ack,
  output logic done_pulse,
  output logic err_set,
  output logic active
);

  localparam logic [HS_CNT_W-1:0] DLY_LAST =
    HS_CNT_W'((ACK_DELAY == 0) ? 0 : ACK_DELAY - 1);
  localparam logic [HS_CNT_W-1:0] TO_LAST =
    HS_CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  logic                req_s;
  hs_state_t           state;
  logic [HS_CNT_W-1:0] cnt;

  if (SYNC_EN) begin : g_sync
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[0], req};
      end
    end
    assign req_s = sync_q[1];
  end else begin : g_direct
    assign req_s = req;
  end

  // ack, done_pulse and err_set all lag the state by one edge, so the top-level
  // counter and sticky error update on the same edge that ack falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ack        <= 1'b0;
      done_pulse <= 1'b0;
      err_set    <= 1'b0;
    end else begin
      ack        <= (state == ACK);
      done_pulse <= 1'b0;
      err_set    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_s) begin
            cnt <= '0;
            if (ACK_DELAY == 0) begin
              state <= ACK;
            end else begin
              state <= DELAY;
            end
          end
        end
        DELAY: begin
          if (!req_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DLY_LAST) begin
            state <= ACK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + HS_CNT_W'(1);
          end
        end
        ACK: begin
          if (!req_s) begin
            state      <= IDLE;
            cnt        <= '0;
            done_pulse <= 1'b1;
          end else if (TO_EN && (cnt == TO_LAST)) begin
            state   <= ERR;
            err_set <= 1'b1;
          end else begin
            cnt <= cnt + HS_CNT_W'(1);
          end
        end
        ERR: begin
          if (!req_s) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign active = (state != IDLE);

endmodule

// File: rtl/handshake_fsm_mc.sv
// Multi-channel four-phase req/ack responder: NUM_CH independent channels plus
// shared sticky error flags, completed-transaction counter and busy indication.
module handshake_fsm_mc
  import hs_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned ACK_DELAY = 2,
  parameter int unsigned TIMEOUT   = 16,
  parameter bit          SYNC_EN   = 1'b1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  handshake_fsm_mc_if.slave bus
);

  logic [NUM_CH-1:0] ack_w;
  logic [NUM_CH-1:0] done_w;
  logic [NUM_CH-1:0] err_set_w;
  logic [NUM_CH-1:0] active_w;
  logic [NUM_CH-1:0] err_q;
  logic [CNT_W-1:0]  txn_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    hs_chan #(
      .ACK_DELAY (ACK_DELAY),
      .TIMEOUT   (TIMEOUT),
      .SYNC_EN   (SYNC_EN)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (bus.req[i]),
      .ack        (ack_w[i]),
      .done_pulse (done_w[i]),
      .err_set    (err_set_w[i]),
      .active     (active_w[i])
    );
  end

  // A channel timing out on the same edge as err_clr keeps its bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      err_q <= (bus.err_clr ? '0 : err_q) | err_set_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_q <= '0;
    end else begin
      txn_q <= txn_q + CNT_W'(hs_popcount8(8'(done_w)));
    end
  end

  assign bus.ack     = ack_w;
  assign bus.err     = err_q;
  assign bus.busy    = |active_w;
  assign bus.txn_cnt = txn_q;

endmodule
